uart_iram_loader: RTL

Serial boot loader feeding the instruction-RAM write port of the debug-wrapped microcontroller. Receives an 8N1 UART byte stream, frames it into 16-bit instruction words and drives `iram_wa`/`iram_wen`/`iram_din` directly. It also produces a `loading` level, which holds the micro in reset while a program is being written.

---
 rtl/uart_iram_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_iram_loader.sv
// UART boot loader: receives 8N1 bytes, frames them as A5 / N / N x (lo,hi) / checksum
// and writes the assembled 16-bit words straight into the instruction RAM.
module uart_iram_loader #(
    parameter int WIDTH          = 16,
    parameter int IRAM_ADDR_BITS = 8,
    parameter int CLKS_PER_BIT   = 868
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [IRAM_ADDR_BITS-1:0] iram_wa,
    output logic                      iram_wen,
    output logic [WIDTH-1:0]          iram_din,
    output logic                      loading,
    output logic                      done,
    output logic                      err
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int HALF      = CLKS_PER_BIT / 2;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // The IDLE cycle that spots the start bit counts as the first half-bit cycle.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_HDR, LD_CNT, LD_LO, LD_HI, LD_CSUM} ld_state_t;

    logic       sync1_q, sync2_q;
    rx_state_t  rx_state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic [7:0] rx_byte_q;
    logic       byte_valid_q;
    logic       frame_err_q;

    ld_state_t  ld_state_q;
    logic [7:0] remaining_q;
    logic [7:0] lo_q;
    logic [7:0] csum_q;
    logic [7:0] csum_d;
    logic [IRAM_ADDR_BITS-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (!sync2_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
                        else                   bit_idx_q  <= bit_idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q      <= '0;
                        rx_byte_q  <= shift_q;
                        rx_state_q <= RX_IDLE;
                        if (sync2_q) byte_valid_q <= 1'b1;
                        else         frame_err_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign csum_d = csum_q ^ rx_byte_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state_q <= LD_HDR;
            loading    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            iram_wen   <= 1'b0;
            iram_wa    <= '0;
            iram_din   <= '0;
            addr_q     <= '0;
        end else begin
            iram_wen <= 1'b0;
            // Already-written words are left in IRAM; only the frame is dropped.
            if (frame_err_q && ld_state_q != LD_HDR) begin
                err        <= 1'b1;
                loading    <= 1'b0;
                ld_state_q <= LD_HDR;
            end else if (byte_valid_q) begin
                case (ld_state_q)
                    LD_HDR: begin
                        if (rx_byte_q == HDR_BYTE) begin
                            loading    <= 1'b1;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            addr_q     <= '0;
                            csum_q     <= '0;
                            ld_state_q <= LD_CNT;
                        end
                    end
                    LD_CNT: begin
                        remaining_q <= rx_byte_q;
                        csum_q      <= rx_byte_q;
                        ld_state_q  <= (rx_byte_q != 8'd0) ? LD_LO : LD_CSUM;
                    end
                    LD_LO: begin
                        lo_q       <= rx_byte_q;
                        csum_q     <= csum_d;
                        ld_state_q <= LD_HI;
                    end
                    LD_HI: begin
                        csum_q      <= csum_d;
                        iram_din    <= {rx_byte_q, lo_q};
                        iram_wa     <= addr_q;
                        iram_wen    <= 1'b1;
                        addr_q      <= addr_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        ld_state_q  <= (remaining_q == 8'd1) ? LD_CSUM : LD_LO;
                    end
                    LD_CSUM: begin
                        if (rx_byte_q == csum_q) done <= 1'b1;
                        else                     err  <= 1'b1;
                        loading    <= 1'b0;
                        ld_state_q <= LD_HDR;
                    end
                    default: ld_state_q <= LD_HDR;
                endcase
            end
        end
    end

endmodule
